// File: rtl/comp_sweep_pkg.sv
// Shared types and constants for the comparator sweep driver.
package comp_sweep_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_state_t;

  localparam int unsigned N_CODES   = 16;
  localparam logic [3:0]  B_DEFAULT = 4'b0011;
  localparam logic [3:0]  LAST_CODE = 4'(N_CODES - 1);

endpackage

// File: rtl/comp_sweep_driver_if.sv
// Comparator-side bus: code bits a..d and constant B out, comparator result Q back.
interface comp_sweep_driver_if;

  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic [3:0] B;
  logic       q_in;

  modport master (output a, b, c, d, B, input q_in);
  modport slave  (input a, b, c, d, B, output q_in);

endinterface

// File: rtl/comp_sweep_driver_hold_counter.sv
// Per-code hold counter: counts 0..HOLD_CYCLES-1 while enabled, strobes on the last cycle.
module sweep_hold_counter #(
  parameter int unsigned HOLD_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int unsigned     W        = $clog2(HOLD_CYCLES);
  localparam logic [W-1:0]    LAST_CNT = W'(HOLD_CYCLES - 1);

  logic [W-1:0] cnt;

  assign last = en && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/comp_sweep_driver.sv
// Sweeps all 16 comparator input codes, captures Q per code into a truth table and checks it.
module comp_sweep_driver
  import comp_sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 5,
  parameter logic [3:0]  B_RESET     = B_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [3:0]          const_b,
  input  logic [N_CODES-1:0]  exp_table,
  comp_sweep_driver_if.master cmp,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_CODES-1:0]  truth_table,
  output logic [4:0]          ones_count
);

  sweep_state_t       state, state_next;
  logic [3:0]         code;
  logic [3:0]         b_reg;
  logic               hold_last;
  logic               go, quit, smp, finish;
  logic [N_CODES-1:0] table_final;

  sweep_hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (go | quit),
    .en    (state == SWEEP),
    .last  (hold_last)
  );

  // Code bits and B come straight from flops so the comparator sees clean edges.
  assign cmp.a = code[3];
  assign cmp.b = code[2];
  assign cmp.c = code[1];
  assign cmp.d = code[0];
  assign cmp.B = b_reg;

  assign busy = (state == SWEEP);
  assign done = (state == DONE);

  // Pass compares against the table including the sample being written this edge.
  assign table_final = truth_table | ({{(N_CODES-1){1'b0}}, cmp.q_in} << code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    go         = 1'b0;
    quit       = 1'b0;
    smp        = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          go         = 1'b1;
          state_next = SWEEP;
        end
      end
      SWEEP: begin
        if (abort) begin
          quit       = 1'b1;
          state_next = IDLE;
        end else if (hold_last) begin
          smp = 1'b1;
          if (code == LAST_CODE) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          quit       = 1'b1;
          state_next = IDLE;
        end else if (start) begin
          go         = 1'b1;
          state_next = SWEEP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code        <= '0;
      b_reg       <= B_RESET;
      pass        <= 1'b0;
      truth_table <= '0;
      ones_count  <= '0;
    end else if (go) begin
      code        <= '0;
      b_reg       <= const_b;
      pass        <= 1'b0;
      truth_table <= '0;
      ones_count  <= '0;
    end else if (quit) begin
      code <= '0;
      pass <= 1'b0;
    end else if (smp) begin
      truth_table <= table_final;
      ones_count  <= ones_count + 5'(cmp.q_in);
      if (finish) pass <= (table_final == exp_table);
      else        code <= code + 1'b1;
    end
  end

endmodule

// File: tb/tb_comp_sweep_driver.sv
// Scoreboard bench for comp_sweep_driver with a behavioural comparator on the bus.
module tb_comp_sweep_driver;
  import comp_sweep_pkg::*;

  localparam int unsigned HOLD      = 5;
  localparam int          SWEEP_LEN = 16 * HOLD;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic        exp_pass;
    logic [3:0]  bv;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  const_b = '0;
  logic [15:0] exp_table = '0;
  logic        busy, done, pass;
  logic [15:0] truth_table;
  logic [4:0]  ones_count;
  bit          gt_mode = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        done_prev = 1'b0;
  exp_t        sb[$];

  comp_sweep_driver_if cmp_if ();

  // Stand-in comparator: '>' or '==' of the 4-bit code against B.
  assign cmp_if.q_in = gt_mode ? ({cmp_if.a, cmp_if.b, cmp_if.c, cmp_if.d} >  cmp_if.B)
                               : ({cmp_if.a, cmp_if.b, cmp_if.c, cmp_if.d} == cmp_if.B);

  comp_sweep_driver #(.HOLD_CYCLES(HOLD), .B_RESET(4'b0011)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .const_b     (const_b),
    .exp_table   (exp_table),
    .cmp         (cmp_if.master),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .truth_table (truth_table),
    .ones_count  (ones_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [15:0] model_table(input bit gt, input logic [3:0] bv);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = gt ? (i > int'(bv)) : (i == int'(bv));
    return t;
  endfunction

  function automatic logic [3:0] code_now();
    return {cmp_if.a, cmp_if.b, cmp_if.c, cmp_if.d};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_table"}, truth_table, 0);
    check({tag, "_ones"}, ones_count, 0);
    check({tag, "_code"}, code_now(), 0);
    check({tag, "_B"}, cmp_if.B, 4'b0011);
  endtask

  // Monitor: follows the oldest expected sweep and checks bus and results at done.
  initial begin
    exp_t r;
    int   n;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && cyc >= sb[0].k) begin
        r = sb[0];
        n = cyc - r.k;
        if (n < SWEEP_LEN) begin
          check("busy_during", busy, 1);
          check("code_during", code_now(), n / HOLD);
          check("B_during", cmp_if.B, r.bv);
        end else begin
          check("done_at_80", done, 1);
          check("busy_at_80", busy, 0);
          check("truth_table", truth_table, r.tt);
          check("ones_count", ones_count, r.cnt);
          check("pass", pass, r.exp_pass);
          check("code_final", code_now(), 15);
          void'(sb.pop_front());
        end
      end else if (sb.size() == 0 && !done_prev) begin
        check("no_spurious_done", done, 0);
      end
      done_prev = done;
    end
  end

  task automatic run_sweep(input bit gt, input logic [3:0] bv, input logic [15:0] expv,
                           input int abort_at, input int rst_at, input bit extra_starts);
    logic [15:0] t;
    exp_t        r;
    int          k;
    @(negedge clk);
    gt_mode   = gt;
    const_b   = bv;
    exp_table = expv;
    start     = 1'b1;
    k         = cyc + 1;
    if (abort_at < 0 && rst_at < 0) begin
      t = model_table(gt, bv);
      r = '{tt: t, cnt: 5'($countones(t)), exp_pass: (t == expv), bv: bv, k: k};
      sb.push_back(r);
    end
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= SWEEP_LEN + 1; n++) begin
      start = extra_starts && (n == 9 || n == 39);
      if (n == abort_at - 1) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_code", code_now(), 0);
        check("abort_B_kept", cmp_if.B, bv);
        return;
      end
      if (n == rst_at - 1) begin
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    bit          gt;
    logic [3:0]  bv;
    logic [15:0] ev;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    run_sweep(1'b1, 4'b0011, 16'hFFF0, -1, -1, 1'b0);
    run_sweep(1'b0, 4'b0011, 16'hFFF0, -1, -1, 1'b0);
    run_sweep(1'b1, 4'b0011, 16'hFFF0, 30, -1, 1'b0);
    run_sweep(1'b1, 4'b0101, model_table(1'b1, 4'b0101), -1, -1, 1'b0);
    run_sweep(1'b1, 4'b0011, 16'hFFF0, -1, -1, 1'b1);
    run_sweep(1'b1, 4'b0011, 16'hFFF0, -1, 47, 1'b0);
    run_sweep(1'b1, 4'b0011, 16'hFFF0, -1, -1, 1'b0);
    run_sweep(1'b0, 4'b0111, model_table(1'b0, 4'b0111), SWEEP_LEN, -1, 1'b0);
    check("abort_final_pass", pass, 0);
    run_sweep(1'b0, 4'b1111, model_table(1'b0, 4'b1111), -1, -1, 1'b0);

    // start and abort together while DONE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("startabort_done", done, 0);
    check("startabort_busy", busy, 0);
    check("startabort_code", code_now(), 0);

    for (int i = 0; i < 6; i++) begin
      gt = 1'($urandom_range(0, 1));
      bv = 4'($urandom);
      ev = ($urandom_range(0, 1) == 1) ? model_table(gt, bv) : 16'($urandom);
      run_sweep(gt, bv, ev, (i == 3) ? int'($urandom_range(1, SWEEP_LEN)) : -1, -1,
                1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
